flag_stack_reg: RTL and testbench

Parametrised status-flag register with a save/restore stack. It holds NFLAGS condition flags (overflow, carry, zero, negative, ...) written by the ALU stage with per-bit enables. Selected flags can be configured as sticky. A DEPTH-entry LIFO lets the control unit save the flags on call/interrupt entry and restore them on return. It replaces the single-bit overflow register in the execute stage; the current flags are read combinationally by branch logic.

---
 rtl/flag_stack_reg.sv | 100 ++++++++++
 tb/tb_flag_stack_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/flag_stack_reg.sv
// Status-flag register with per-bit write enables, sticky bits and a LIFO
// save/restore stack for call/interrupt entry and return.
module flag_stack_reg #(
  parameter int unsigned       NFLAGS      = 4,
  parameter int unsigned       DEPTH       = 4,
  parameter logic [NFLAGS-1:0] STICKY_MASK = '0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NFLAGS-1:0]          flagIn,
  input  logic [NFLAGS-1:0]          flagWrite,
  input  logic [NFLAGS-1:0]          clearFlags,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       errClr,
  output logic [NFLAGS-1:0]          flagOut,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  localparam int unsigned DW = $clog2(DEPTH+1);

  logic [NFLAGS-1:0] flags;
  logic [NFLAGS-1:0] stack [DEPTH];
  logic [DW-1:0]     cnt;
  logic              err_q;

  logic [NFLAGS-1:0] merged;
  logic [NFLAGS-1:0] written;
  logic [NFLAGS-1:0] top;
  logic              is_empty;
  logic              is_full;
  logic              push_only;
  logic              pop_only;
  logic              exchange;
  logic              do_pop;
  logic              stack_we;
  logic              misuse;
  logic [DW-1:0]     wr_idx;

  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < NFLAGS; i++) begin
      if (STICKY_MASK[i])
        merged[i] = flags[i] | (flagWrite[i] & flagIn[i]);
      else
        merged[i] = flagWrite[i] ? flagIn[i] : flags[i];
    end
    written = merged & ~clearFlags;
  end

  // Stack is read by matching depth per entry so the index width never has
  // to agree with the array size.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (cnt == DW'(i + 1)) top = stack[i];
    end
  end

  always_comb begin
    is_empty  = (cnt == '0);
    is_full   = (cnt == DW'(DEPTH));
    push_only = push && !pop && !is_full;
    pop_only  = pop && !push && !is_empty;
    exchange  = push && pop && !is_empty;
    do_pop    = pop && !is_empty;
    stack_we  = push_only || exchange;
    wr_idx    = exchange ? (cnt - DW'(1)) : cnt;
    misuse    = (push && !pop && is_full) || (pop && is_empty);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flags <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      flags <= do_pop ? top : written;
      if (push_only)
        cnt <= cnt + DW'(1);
      else if (pop_only)
        cnt <= cnt - DW'(1);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (stack_we && (wr_idx == DW'(i))) stack[i] <= flags;
      end
      err_q <= misuse | (err_q & ~errClr);
    end
  end

  assign flagOut = flags;
  assign depth   = cnt;
  assign empty   = is_empty;
  assign full    = is_full;
  assign err     = err_q;

endmodule

// File: tb/tb_flag_stack_reg.sv
// Bench for flag_stack_reg: directed scenarios pinned with literal values plus
// randomized traffic, all checked against a queue-based reference model.
module tb_flag_stack_reg;

  localparam int unsigned NF = 4;
  localparam int unsigned DP = 2;
  localparam logic [NF-1:0] SM = 4'b0010;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [NF-1:0] flagIn, flagWrite, clearFlags;
  logic          push, pop, errClr;
  logic [NF-1:0] flagOut;
  logic [1:0]    depth;
  logic          empty, full, err;

  flag_stack_reg #(.NFLAGS(NF), .DEPTH(DP), .STICKY_MASK(SM)) dut (
    .CLK(CLK), .RST_N(RST_N), .flagIn(flagIn), .flagWrite(flagWrite),
    .clearFlags(clearFlags), .push(push), .pop(pop), .errClr(errClr),
    .flagOut(flagOut), .depth(depth), .empty(empty), .full(full), .err(err)
  );

  always #5 CLK = ~CLK;

  int unsigned nchk  = 0;
  int unsigned npass = 0;
  bit          chk_en = 1'b0;

  logic [NF-1:0] m_flags;
  logic [NF-1:0] m_stack[$];
  bit            m_err;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    m_flags = '0;
    m_stack.delete();
    m_err = 1'b0;
  endfunction

  function automatic logic [NF-1:0] apply_write(logic [NF-1:0] cur, logic [NF-1:0] in,
                                                logic [NF-1:0] wr, logic [NF-1:0] clr);
    logic [NF-1:0] sticky_v, plain_v;
    sticky_v = cur | (wr & in);
    plain_v  = (wr & in) | (~wr & cur);
    return ((SM & sticky_v) | (~SM & plain_v)) & ~clr;
  endfunction

  function automatic void model_step(logic [NF-1:0] in, logic [NF-1:0] wr, logic [NF-1:0] clr,
                                     bit ps, bit pp, bit ec);
    bit misuse;
    logic [NF-1:0] t;
    misuse = (ps && !pp && m_stack.size() == DP) || (pp && m_stack.size() == 0);
    if (pp && m_stack.size() > 0) begin
      t = m_stack.pop_back();
      if (ps) m_stack.push_back(m_flags);
      m_flags = t;
    end else begin
      if (ps && !pp && m_stack.size() < DP) m_stack.push_back(m_flags);
      m_flags = apply_write(m_flags, in, wr, clr);
    end
    m_err = misuse | (m_err & !ec);
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      check("flagOut", 32'(flagOut), 32'(m_flags));
      check("depth",   32'(depth),   32'(m_stack.size()));
      check("empty",   32'(empty),   32'(m_stack.size() == 0));
      check("full",    32'(full),    32'(m_stack.size() == DP));
      check("err",     32'(err),     32'(m_err));
    end
  end

  task automatic cycle(input logic [NF-1:0] in, input logic [NF-1:0] wr,
                       input logic [NF-1:0] clr, input bit ps, input bit pp, input bit ec);
    flagIn = in; flagWrite = wr; clearFlags = clr;
    push = ps; pop = pp; errClr = ec;
    @(posedge CLK);
    if (!RST_N) model_reset();
    else model_step(in, wr, clr, ps, pp, ec);
    #1;
  endtask

  task automatic idle();
    cycle('0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_flagOut"}, 32'(flagOut), 32'h0);
    check({tag, "_depth"},   32'(depth),   32'h0);
    check({tag, "_empty"},   32'(empty),   32'h1);
    check({tag, "_full"},    32'(full),    32'h0);
    check({tag, "_err"},     32'(err),     32'h0);
  endtask

  initial begin
    RST_N = 1'b0;
    flagIn = '0; flagWrite = '0; clearFlags = '0;
    push = 1'b0; pop = 1'b0; errClr = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    chk_en = 1'b1;

    // Reset and basic write
    cycle(4'b1011, 4'b1111, '0, 0, 0, 0);
    check("basic_write", 32'(flagOut), 32'hB);
    #2; RST_N = 1'b0; model_reset(); #1;
    check_reset_outputs("async_rst");
    idle();
    RST_N = 1'b1;
    cycle(4'b1011, 4'b1111, '0, 0, 0, 0);
    check("write_after_rst", 32'(flagOut), 32'hB);

    // Sticky and clear
    cycle('0, '0, 4'hF, 0, 0, 0);
    cycle(4'b0000, 4'b1111, '0, 0, 0, 0);
    check("sticky_zero_write", 32'(flagOut), 32'h0);
    cycle(4'b0010, 4'b0010, '0, 0, 0, 0);
    cycle(4'b0000, 4'b1111, '0, 0, 0, 0);
    check("sticky_holds", 32'(flagOut), 32'h2);
    cycle(4'b0010, 4'b0010, 4'b0010, 0, 0, 0);
    check("clear_beats_write", 32'(flagOut), 32'h0);

    // Push/pop round trip
    cycle(4'hA, 4'hF, '0, 0, 0, 0);
    check("flags_A", 32'(flagOut), 32'hA);
    cycle(4'h5, 4'hF, 4'b0010, 1, 0, 0);
    check("push1_flags", 32'(flagOut), 32'h5);
    check("push1_depth", 32'(depth), 32'd1);
    cycle('0, '0, '0, 1, 0, 0);
    check("push2_depth", 32'(depth), 32'd2);
    check("push2_full", 32'(full), 32'd1);
    cycle(4'hF, 4'hF, 4'hF, 0, 1, 0);
    check("pop1_flags", 32'(flagOut), 32'h5);
    cycle('0, '0, '0, 0, 1, 0);
    check("pop2_flags", 32'(flagOut), 32'hA);
    check("pop2_empty", 32'(empty), 32'd1);

    // Overflow / underflow
    cycle('0, '0, '0, 1, 0, 0);
    cycle('0, '0, '0, 1, 0, 0);
    cycle('0, '0, '0, 1, 0, 0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_depth", 32'(depth), 32'd2);
    cycle('0, '0, '0, 0, 0, 1);
    check("errclr", 32'(err), 32'd0);
    cycle('0, '0, '0, 0, 1, 0);
    cycle('0, '0, '0, 0, 1, 0);
    check("ovf_stack_intact", 32'(flagOut), 32'hA);
    cycle(4'h3, 4'hF, '0, 0, 1, 0);
    check("udf_err", 32'(err), 32'd1);
    check("udf_flags", 32'(flagOut), 32'h3);
    cycle('0, '0, '0, 0, 0, 1);
    cycle('0, '0, '0, 1, 1, 1);
    check("set_beats_clr", 32'(err), 32'd1);

    // Exchange
    cycle('0, '0, 4'hF, 0, 0, 1);
    cycle(4'h7, 4'hF, '0, 0, 0, 0);
    cycle(4'h2, 4'hF, '0, 1, 0, 0);
    check("xchg_pre_flags", 32'(flagOut), 32'h2);
    cycle(4'hF, 4'hF, '0, 1, 1, 0);
    check("xchg_flags", 32'(flagOut), 32'h7);
    check("xchg_depth", 32'(depth), 32'd1);
    cycle('0, '0, '0, 0, 1, 0);
    check("xchg_stack_top", 32'(flagOut), 32'h2);

    // Reset in the middle of a pop
    cycle('0, '0, '0, 1, 0, 0);
    cycle('0, '0, '0, 1, 0, 0);
    check("pre_rst_depth", 32'(depth), 32'd2);
    pop = 1'b1;
    #2; RST_N = 1'b0; model_reset(); #1;
    check_reset_outputs("rst_mid_pop");
    idle();
    RST_N = 1'b1;
    cycle('0, '0, '0, 0, 1, 0);
    check("pop_after_rst_err", 32'(err), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [NF-1:0] r_in, r_wr, r_clr;
      bit r_ps, r_pp, r_ec;
      r_in  = NF'($urandom);
      r_wr  = NF'($urandom);
      r_clr = NF'($urandom & $urandom & $urandom);
      r_ps  = ($urandom_range(0, 2) == 0);
      r_pp  = ($urandom_range(0, 2) == 0);
      r_ec  = ($urandom_range(0, 7) == 0);
      RST_N = ($urandom_range(0, 99) != 0);
      if (!RST_N) model_reset();
      cycle(r_in, r_wr, r_clr, r_ps, r_pp, r_ec);
    end
    RST_N = 1'b1;
    idle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
